// File: rtl/cv32e41p_sleep_ctrl.sv
// Sleep/wake controller that drives the core clock-gate enable.
// Runs on the free-running clock and tracks boot, WFI drain, sleep and wake settle.
module cv32e41p_sleep_ctrl #(
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk_ungated_i,
  input  logic rst_n,
  input  logic fetch_enable_i,
  input  logic wfi_req_i,
  input  logic core_busy_i,
  input  logic irq_pending_i,
  input  logic debug_req_i,
  output logic clock_en_o,
  output logic fetch_enable_o,
  output logic core_sleep_o
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SLEEP = 3'd3;
  localparam logic [2:0] S_WAKE  = 3'd4;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wake_evt;

  assign wake_evt = irq_pending_i | debug_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: begin
        if (fetch_enable_i) state_d = S_RUN;
      end
      S_RUN: begin
        // A wake event coinciding with WFI keeps the core running.
        if (wfi_req_i && !wake_evt) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wake_evt)          state_d = S_RUN;
        else if (!core_busy_i) state_d = S_SLEEP;
      end
      S_SLEEP: begin
        if (wake_evt) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (cnt_q == 4'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs are flopped from the next state so they move on the same edge as the state.
  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_BOOT;
      cnt_q          <= 4'd0;
      clock_en_o     <= 1'b0;
      fetch_enable_o <= 1'b0;
      core_sleep_o   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      clock_en_o     <= (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_WAKE);
      core_sleep_o   <= (state_d == S_SLEEP) || (state_d == S_WAKE);
      fetch_enable_o <= fetch_enable_o | (state_d != S_BOOT);
    end
  end

endmodule

// File: tb/tb_cv32e41p_sleep_ctrl.sv
// Bench for cv32e41p_sleep_ctrl: directed test-plan steps followed by random cycles,
// all checked against a cycle-stamp reference model.
module tb_cv32e41p_sleep_ctrl;

  localparam int unsigned W = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_enable_i, wfi_req_i, core_busy_i, irq_pending_i, debug_req_i;
  logic clock_en_o, fetch_enable_o, core_sleep_o;

  int vectors = 0;
  int miscompares = 0;

  cv32e41p_sleep_ctrl #(.WAKE_CYCLES(W)) dut (
    .clk_ungated_i (clk),
    .rst_n         (rst_n),
    .fetch_enable_i(fetch_enable_i),
    .wfi_req_i     (wfi_req_i),
    .core_busy_i   (core_busy_i),
    .irq_pending_i (irq_pending_i),
    .debug_req_i   (debug_req_i),
    .clock_en_o    (clock_en_o),
    .fetch_enable_o(fetch_enable_o),
    .core_sleep_o  (core_sleep_o)
  );

  always #5 clk = ~clk;

  // Reference model: a mode plus the cycle stamp of the last wake.
  typedef enum {M_BOOT, M_RUN, M_DRAIN, M_SLEEP, M_WAKE} mode_t;
  mode_t m_mode;
  logic  m_fe;
  int    cyc;
  int    wake_cyc;

  task automatic model_reset();
    m_mode = M_BOOT;
    m_fe   = 1'b0;
  endtask

  task automatic model_edge();
    logic wake;
    cyc++;
    if (!rst_n) return;
    wake = irq_pending_i | debug_req_i;
    case (m_mode)
      M_BOOT:  if (fetch_enable_i) begin m_mode = M_RUN; m_fe = 1'b1; end
      M_RUN:   if (wfi_req_i && !wake) m_mode = M_DRAIN;
      M_DRAIN: if (wake) m_mode = M_RUN; else if (!core_busy_i) m_mode = M_SLEEP;
      M_SLEEP: if (wake) begin m_mode = M_WAKE; wake_cyc = cyc; end
      M_WAKE:  if (cyc - wake_cyc >= int'(W)) m_mode = M_RUN;
      default: m_mode = M_BOOT;
    endcase
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    check("clock_en", clock_en_o, m_mode inside {M_RUN, M_DRAIN, M_WAKE});
    check("core_sleep", core_sleep_o, m_mode inside {M_SLEEP, M_WAKE});
    check("fetch_enable", fetch_enable_o, m_fe);
  endtask

  task automatic step(input logic fe, input logic wfi, input logic busy,
                      input logic irq, input logic dbg);
    fetch_enable_i = fe;
    wfi_req_i      = wfi;
    core_busy_i    = busy;
    irq_pending_i  = irq;
    debug_req_i    = dbg;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    check("async_clock_en", clock_en_o, 1'b0);
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    wake_cyc = 0;
    fetch_enable_i = 1'b0; wfi_req_i = 1'b0; core_busy_i = 1'b0;
    irq_pending_i = 1'b0; debug_req_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    do_reset();

    // Boot hold then release; fetch enable must be sticky.
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("boot_hold_clock_en", clock_en_o, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("boot_clock_en", clock_en_o, 1'b1);
    check("boot_fetch_en", fetch_enable_o, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sticky_fetch_en", fetch_enable_o, 1'b1);

    // WFI with busy core: drain held, then sleep once busy drops.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drain_clock_en", clock_en_o, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sleep_clock_en", clock_en_o, 1'b0);
    check("sleep_core_sleep", core_sleep_o, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Irq pulse wakes; wfi and irq toggles during settle are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wake_clock_en", clock_en_o, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("wake_settle_sleep", core_sleep_o, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wake_done_sleep", core_sleep_o, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Debug abort of drain on the same edge as busy drop; wfi+irq in run.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("abort_clock_en", clock_en_o, 1'b1);
    check("abort_core_sleep", core_sleep_o, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wfi_irq_clock_en", clock_en_o, 1'b1);

    // Reset mid-sleep.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-wake.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cv32e41p_sleep_ctrl.md
# cv32e41p_sleep_ctrl

Sleep/wake controller that produces the enable for the core clock gate. It runs on the free-running (ungated) clock and tracks boot fetch enable and WFI requests. It drains the core before gating and re-enables the clock on interrupt or debug wake events, holding the core in a settle phase before release. Its `clock_en_o` drives the clock gate's enable input; `core_sleep_o` is the SoC-visible sleep indication.

## Interface
- `WAKE_CYCLES`, default 2: cycles the clock runs after wake before `core_sleep_o` drops; legal range 1..15.
- `clk_ungated_i`  in  1  free-running clock; never gated.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_enable_i`  in  1  SoC boot enable; level, sampled every cycle.
- `wfi_req_i`  in  1  core requests sleep (WFI decoded); level.
- `core_busy_i`  in  1  core has outstanding fetch/LSU/pipeline activity.
- `irq_pending_i`  in  1  enabled interrupt pending (wake event).
- `debug_req_i`  in  1  debug halt request (wake event).
- `clock_en_o`  out  1  enable to the core clock gate.
- `fetch_enable_o`  out  1  sticky fetch enable to the core.
- `core_sleep_o`  out  1  core is asleep or settling after wake.

## Operation
- The wake event is `irq_pending_i | debug_req_i`.
- States: BOOT, RUN, DRAIN, SLEEP, WAKE. All outputs are registered and derived from the state.
- Reset values: state BOOT, `clock_en_o`=0, `fetch_enable_o`=0, `core_sleep_o`=0, wake counter 0.
- BOOT:
  - `fetch_enable_i`=1 → RUN.
  - Otherwise stay; wfi and wake events are ignored.
- RUN (`clock_en_o`=1, `fetch_enable_o`=1):
  - `wfi_req_i`=1 and no wake event → DRAIN.
  - `wfi_req_i`=1 together with a wake event → stay in RUN. The wake event has priority.
- DRAIN (`clock_en_o`=1):
  - Wake event → RUN (abort).
  - Else `core_busy_i`=0 → SLEEP.
  - Else stay.
  - The wake event has priority over busy=0 in the same cycle.
- SLEEP (`clock_en_o`=0, `core_sleep_o`=1):
  - Wake event → WAKE, loading the counter with `WAKE_CYCLES`-1.
  - `wfi_req_i` and `core_busy_i` are ignored.
- WAKE (`clock_en_o`=1, `core_sleep_o`=1):
  - Counter decrements each cycle; at 0 → RUN.
  - Wake events and `wfi_req_i` are ignored; no re-sleep until RUN.
- `fetch_enable_o` is set on leaving BOOT and cleared only by reset. It ignores later `fetch_enable_i`=0.
- Counter width is 4 bits. It never wraps, because it loads only on SLEEP→WAKE and stops at 0.
- Reset asserted in any state returns the block to BOOT asynchronously, so `clock_en_o` drops immediately.
- Unreachable state encodings → BOOT.

## Timing
- Inputs are sampled on the rising edge of `clk_ungated_i`. Output changes are visible after the same edge as the state change.
- Boot: `fetch_enable_i`=1 at edge k → `clock_en_o`=`fetch_enable_o`=1 after edge k.
- Sleep entry, minimum 2 cycles:
  - `wfi_req_i`=1 at edge k → DRAIN after k.
  - `core_busy_i`=0 at edge k+1 → SLEEP, with `clock_en_o`=0 and `core_sleep_o`=1 after edge k+1.
- Wake:
  - Wake event at edge j in SLEEP → `clock_en_o`=1 after edge j.
  - `core_sleep_o` falls after edge j+`WAKE_CYCLES`.
- `clock_en_o` is glitch-free: it is a flop output and changes only after rising edges. The downstream gate's low-phase latch absorbs it.

## Test plan
- Reset, then `fetch_enable_i`=0 for 10 cycles, then 1 → all outputs 0 for 10 cycles; `clock_en_o` and `fetch_enable_o` rise one edge after the 1 is sampled; `fetch_enable_i`→0 later leaves `fetch_enable_o`=1.
- In RUN, `wfi_req_i`=1 with `core_busy_i`=1 for 5 cycles then 0 → DRAIN held 5 cycles; `clock_en_o`=0 and `core_sleep_o`=1 the cycle after busy drops.
- In SLEEP, `irq_pending_i` pulse 1 cycle with `WAKE_CYCLES`=3 → `clock_en_o`=1 next cycle; `core_sleep_o` stays 1 for 3 more cycles, then 0 (RUN).
- In DRAIN, `debug_req_i`=1 with `core_busy_i`=0 on the same edge → RUN, `clock_en_o` never drops. `wfi_req_i`=1 with `irq_pending_i`=1 in RUN → stays RUN.
- In WAKE, `wfi_req_i`=1 and an irq toggle → no state effect; RUN reached exactly `WAKE_CYCLES` cycles after wake. A new `wfi_req_i` in RUN re-enters DRAIN.
- Assert `rst_n`=0 mid-SLEEP and mid-WAKE → outputs 0 immediately, without waiting for a clock edge; after release, block in BOOT awaiting `fetch_enable_i`.
